icache_nway: RTL
================

# icache_nway

Parametrised N-way set-associative instruction cache between the IF stage and the instruction memory port. It is the successor to the fixed 2-way/8-set/16-byte I-cache, with configurable geometry, round-robin replacement with invalid-way priority, and a defined redirect-during-refill rule. An optional whole-cache invalidate (fence.i) is also provided. Hits return one 32-bit word per request; misses fetch one full line from memory.

## Interface
- `WAYS`, 2: associativity; power of two, 1..8.
- `SETS`, 8: set count; power of two, ≥2.
- `LINE_BYTES`, 16: line size; power of two, 8..64.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_pc_i` in 32: fetch address; bits [1:0] ignored.
- `if_req_i` in 1: fetch request, level.
- `stall_i` in 1: back-pressure from flow control.
- `redirect_i` in 1: jump/branch redirect; `if_pc_i` already carries the new PC.
- `inst_o` out 32: fetched word.
- `ready_o` out 1: `inst_o` valid this cycle.
- `hit_o` out 1: combinational tag hit for `if_pc_i`; independent of `if_req_i`.
- `req_again_o` out 1: IF must re-present its request.
- `mem_addr_o` out 32: line-aligned refill address.
- `mem_req_o` out 1: refill request; single-cycle pulse.
- `mem_ready_i` in 1: refill data valid; single-cycle pulse.
- `mem_data_i` in LINE_BYTES*8: refill line; word k is in bits [32k+31:32k].
- `flush_i` in 1: invalidate all; present only with `ICACHE_FLUSH_EN`.
- `flush_done_o` out 1: invalidate complete; present only with `ICACHE_FLUSH_EN`.

## Operation
- Address split: offset = log2(LINE_BYTES); index = log2(SETS); tag = the remaining upper bits. Word select = pc[offset-1:2].
- Storage per way/set: valid bit, tag, line data. Per set: a round-robin pointer of log2(WAYS) bits, minimum 1 bit.
- Reset: all valid bits 0, all pointers 0, FSM in IDLE. All outputs 0: `inst_o`=0, `ready_o`=0, `mem_req_o`=0, `mem_addr_o`=0, `req_again_o`=0, `flush_done_o`=0.
- **IDLE**, priority order:
  - `stall_i`: `ready_o`←0, `req_again_o`←1, no lookup.
  - Else `if_req_i` and hit: `inst_o`←selected word, `ready_o`←1.
  - Else `if_req_i` and miss: `mem_req_o`←1 for one cycle, `mem_addr_o`←pc with offset bits cleared; latch index, tag and word select; choose the victim; go to REFILL.
  - Else: `ready_o`←0, `inst_o`←0.
  - `req_again_o`←0 in every non-stall cycle.
- Hits never update replacement state.
- Victim selection: the lowest-numbered invalid way; if all ways are valid, the way at the set pointer. The pointer increments modulo WAYS only when a valid way is replaced.
- **REFILL**:
  - Wait for `mem_ready_i`. On arrival, write data, tag and valid into the victim way, then return to IDLE.
  - Normal refill: `inst_o`←latched word from `mem_data_i`, `ready_o`←1.
  - If `redirect_i` was seen at any cycle during REFILL: the line is still written, `ready_o` stays 0, and `req_again_o` is pulsed 1. The memory request is never cancelled and never re-issued while in REFILL.
  - `mem_ready_i` and `redirect_i` in the same cycle count as a redirect.
- `mem_ready_i` outside REFILL is ignored.

## Timing
- Hit: request in cycle N gives `ready_o`/`inst_o` in cycle N+1. Back-to-back hits sustain one word per cycle.
- Miss: `mem_req_o` in N+1. If `mem_ready_i` arrives in cycle M, `ready_o` is asserted in M+1 and a new lookup is possible in M+1.
- A refilled line hits for a request presented in M+1.
- `ready_o` is a single-cycle pulse per delivered word.
- `rst` during REFILL discards the refill; a later `mem_ready_i` is ignored.

## Configuration
- `ICACHE_FLUSH_EN` defined:
  - Adds the FLUSH state and the `flush_i`/`flush_done_o` ports.
  - `flush_i` in IDLE takes priority over `stall_i` and `if_req_i`. FLUSH clears all ways of one set per cycle, SETS cycles in total, and resets the pointers.
  - `flush_done_o` pulses for 1 cycle in the cycle after the last set is cleared; the FSM then returns to IDLE.
  - `flush_i` during REFILL is latched and taken after the refill completes, ahead of the next lookup.
- `ICACHE_FLUSH_EN` undefined: no flush ports, no FLUSH state; valid bits clear only on `rst`.

## Structure
- Package `icache_pkg`: FSM state enum (IDLE, REFILL, FLUSH) and the address-field width functions for offset, index and tag.
- One sub-module, `icache_victim_sel`: combinational. Inputs are the valid vector and the set pointer; outputs are the victim way and the replace-valid flag.

## Test plan
- Cold miss at pc 0x0000_0104 (default parameters): `mem_req_o`=1 with `mem_addr_o`=0x0000_0100. When `mem_ready_i` delivers the line, `inst_o`=word 1 and `ready_o` is asserted the next cycle. A re-request of 0x104 then hits with 1-cycle latency.
- Fill both ways of set 0 (0x000, 0x080), then miss on 0x100: way 0 is replaced and the pointer becomes 1. A further miss on 0x180 replaces way 1.
- `redirect_i` during REFILL, then `mem_ready_i` three cycles later: `ready_o` stays 0, `req_again_o`=1, and the line is valid (the next request to it hits).
- `stall_i` held for 2 cycles while `if_req_i` is 1: no `ready_o`, `req_again_o`=1 for those cycles, no `mem_req_o`.
- With `ICACHE_FLUSH_EN`: fill 4 lines, pulse `flush_i` → `flush_done_o` after 8 cycles, and all subsequent requests miss.
- WAYS=4, SETS=4, LINE_BYTES=32: fetch 5 lines that map to one set. The first 4 fill ways 0-3; the 5th replaces way 0.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-field width helpers for icache_nway.
//   state_e  - refill/flush controller states
//   off_w    - byte-offset field width for a given line size
//   idx_w    - set-index field width for a given set count
//   tag_w    - tag field width (remaining upper bits of a 32-bit PC)
//   ptr_w    - round-robin pointer width (at least one bit)
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    function automatic int unsigned off_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned line_bytes,
                                          input int unsigned sets);
        return 32 - $clog2(line_bytes) - $clog2(sets);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: combinational replacement-way chooser for one set.
//   valid_i      - valid bit of every way in the set
//   ptr_i        - round-robin pointer of the set
//   victim_o     - way to refill: lowest invalid way, else the pointed way
//   repl_valid_o - 1 when the victim holds a valid line (pointer must advance)
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned PTR_W = ptr_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] victim_o,
    output logic             repl_valid_o
);

    logic found;

    always_comb begin
        victim_o     = ptr_i;
        repl_valid_o = 1'b1;
        found        = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim_o     = PTR_W'(w);
                repl_valid_o = 1'b0;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache, IF stage <-> memory.
//   if_pc_i/if_req_i/stall_i/redirect_i - fetch request side
//   inst_o/ready_o                       - fetched word, valid for one cycle
//   hit_o                                - combinational tag hit for if_pc_i
//   req_again_o                          - IF must re-present its request
//   mem_addr_o/mem_req_o                 - line refill request (1-cycle pulse)
//   mem_ready_i/mem_data_i               - refill line return (1-cycle pulse)
//   flush_i/flush_done_o                 - whole-cache invalidate, only when
//                                          ICACHE_FLUSH_EN is defined
module icache_nway
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 8,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             if_pc_i,
    input  logic                    if_req_i,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    output logic [31:0]             inst_o,
    output logic                    ready_o,
    output logic                    hit_o,
    output logic                    req_again_o,
    output logic [31:0]             mem_addr_o,
    output logic                    mem_req_o,
`ifdef ICACHE_FLUSH_EN
    input  logic                    flush_i,
    output logic                    flush_done_o,
`endif
    input  logic                    mem_ready_i,
    input  logic [LINE_BYTES*8-1:0] mem_data_i
);

    localparam int unsigned OFF_W  = off_w(LINE_BYTES);
    localparam int unsigned IDX_W  = idx_w(SETS);
    localparam int unsigned TAG_W  = tag_w(LINE_BYTES, SETS);
    localparam int unsigned PTR_W  = ptr_w(WAYS);
    localparam int unsigned WSEL_W = OFF_W - 2;
    localparam int unsigned LINE_W = LINE_BYTES * 8;

    // Address fields of the incoming PC
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [WSEL_W-1:0] pc_wsel;
    logic [1:0]        unused_pc_bits;
    assign pc_idx         = if_pc_i[OFF_W +: IDX_W];
    assign pc_tag         = if_pc_i[31 -: TAG_W];
    assign pc_wsel        = if_pc_i[2 +: WSEL_W];
    assign unused_pc_bits = if_pc_i[1:0];

    // Storage
    logic [WAYS-1:0]   valid_q [SETS];
    logic [PTR_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];

    // Miss context latched when the refill is issued
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  mtag_q;
    logic [WSEL_W-1:0] wsel_q;
    logic [PTR_W-1:0]  way_q;
    logic              repl_q;
    logic              redir_q;

    state_e state_q, state_d;

    logic [31:0] inst_q, inst_d, mem_addr_q, mem_addr_d;
    logic        ready_q, ready_d, req_again_q, req_again_d, mem_req_q, mem_req_d;
    logic        flush_done_d;

    // Tag lookup
    logic              hit;
    logic [PTR_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[pc_idx][w] && (tag_q[w][pc_idx] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    assign hit_line = data_q[hit_way][pc_idx];
    assign hit_o    = hit;

    logic [PTR_W-1:0] vict_way;
    logic             vict_repl;

    icache_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_victim (
        .valid_i      (valid_q[pc_idx]),
        .ptr_i        (ptr_q[pc_idx]),
        .victim_o     (vict_way),
        .repl_valid_o (vict_repl)
    );

    logic flush_go;
    logic miss_go;
    logic refill_done;
    logic redir_now;

`ifdef ICACHE_FLUSH_EN
    logic             flush_pend_q;
    logic [IDX_W-1:0] fcnt_q;
    logic             flush_done_q;
    assign flush_go     = flush_i | flush_pend_q;
    assign flush_done_o = flush_done_q;
`else
    assign flush_go = 1'b0;
`endif

    assign miss_go     = (state_q == ST_IDLE) && !flush_go && !stall_i && if_req_i && !hit;
    assign refill_done = (state_q == ST_REFILL) && mem_ready_i;
    // A redirect in the completing cycle counts just like an earlier one
    assign redir_now   = redir_q | redirect_i;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_go)     state_d = ST_FLUSH;
                else if (miss_go) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                if (mem_ready_i) state_d = ST_IDLE;
            end
`ifdef ICACHE_FLUSH_EN
            ST_FLUSH: begin
                if (fcnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic (registered outputs, next values computed here)
    always_comb begin
        inst_d       = '0;
        ready_d      = 1'b0;
        req_again_d  = 1'b0;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_go) begin
                    // outputs stay idle while the invalidate runs
                end else if (stall_i) begin
                    req_again_d = 1'b1;
                end else if (if_req_i && hit) begin
                    inst_d  = hit_line[32*pc_wsel +: 32];
                    ready_d = 1'b1;
                end else if (if_req_i) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {if_pc_i[31:OFF_W], {OFF_W{1'b0}}};
                end
            end
            ST_REFILL: begin
                if (mem_ready_i) begin
                    if (redir_now) begin
                        req_again_d = 1'b1;
                    end else begin
                        inst_d  = mem_data_i[32*wsel_q +: 32];
                        ready_d = 1'b1;
                    end
                end
            end
`ifdef ICACHE_FLUSH_EN
            ST_FLUSH: flush_done_d = (fcnt_q == IDX_W'(SETS - 1));
`endif
            default: ;
        endcase
    end

    // State register, control state and valid/pointer arrays
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            inst_q      <= '0;
            ready_q     <= 1'b0;
            req_again_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            redir_q     <= 1'b0;
            idx_q       <= '0;
            mtag_q      <= '0;
            wsel_q      <= '0;
            way_q       <= '0;
            repl_q      <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
`ifdef ICACHE_FLUSH_EN
            flush_pend_q <= 1'b0;
            fcnt_q       <= '0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            ready_q     <= ready_d;
            req_again_q <= req_again_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;

            if (miss_go) begin
                idx_q  <= pc_idx;
                mtag_q <= pc_tag;
                wsel_q <= pc_wsel;
                way_q  <= vict_way;
                repl_q <= vict_repl;
            end

            if (refill_done) begin
                valid_q[idx_q][way_q] <= 1'b1;
                redir_q               <= 1'b0;
                if (repl_q) begin
                    ptr_q[idx_q] <= (ptr_q[idx_q] == PTR_W'(WAYS - 1)) ? '0
                                                                        : ptr_q[idx_q] + 1'b1;
                end
            end else if ((state_q == ST_REFILL) && redirect_i) begin
                redir_q <= 1'b1;
            end

`ifdef ICACHE_FLUSH_EN
            flush_done_q <= flush_done_d;
            // A flush seen during a refill waits for the refill to finish
            if ((state_q == ST_REFILL) && flush_i) flush_pend_q <= 1'b1;
            if ((state_q == ST_IDLE) && flush_go) begin
                flush_pend_q <= 1'b0;
                fcnt_q       <= '0;
            end
            if (state_q == ST_FLUSH) begin
                valid_q[fcnt_q] <= '0;
                ptr_q[fcnt_q]   <= '0;
                fcnt_q          <= fcnt_q + 1'b1;
            end
`endif
        end
    end

    // Tag/data arrays need no reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_q[way_q][idx_q]  <= mtag_q;
            data_q[way_q][idx_q] <= mem_data_i;
        end
    end

    assign inst_o      = inst_q;
    assign ready_o     = ready_q;
    assign req_again_o = req_again_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;

endmodule
